mult_share_sched: RTL and testbench

- Shares one `sequential_multiplier` instance among NUM_REQ requesters.
- Per-requester valid/ready request ports; round-robin arbitration.
- Sequences the multiplier's clear/enable/done protocol and returns the 2N-bit product, tagged with the requester ID, on a single valid/ready response port.
- Sits between client blocks and the multiplier, replacing the fixed input and output registers of the single-user integration.

---
 rtl/mult_sched_pkg.sv | 17 +
 rtl/mult_share_sched_rr_arbiter.sv | 36 +++
 rtl/mult_share_sched.sv | 113 +++++++++++
 tb/tb_mult_share_sched.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the shared-multiplier scheduler.
package mult_sched_pkg;

  localparam int N_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int id_width(input int num_req);
    return ($clog2(num_req) < 1) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, with wrap.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  int              sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = int'(ptr) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one sequential multiplier among NUM_REQ valid/ready requesters.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands skip the multiplier.
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [2*N-1:0]       resp_result,
  output logic                 mult_clear,
  output logic                 mult_en,
  output logic [N-1:0]         mult_a,
  output logic [N-1:0]         mult_b,
  input  logic [2*N-1:0]       mult_result,
  input  logic                 mult_done,
  output logic                 busy
);

  // state | meaning
  // IDLE  | arbitrating; the granted requester sees req_ready
  // ISSUE | one-cycle multiplier clear with operands already latched
  // BUSY  | multiplier enabled, waiting for mult_done
  // RESP  | product held on the response port until resp_ready

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     id_q;
  logic [ID_W-1:0]     next_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any_grant;
  logic [N-1:0]        a_sel;
  logic [N-1:0]        b_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign a_sel    = req_a[int'(grant_idx)*N +: N];
  assign b_sel    = req_b[int'(grant_idx)*N +: N];
  assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Ready is masked during reset so no accept can be pending across it.
  assign req_ready  = (state == IDLE && !reset) ? grant : '0;
  assign resp_valid = (state == RESP);
  assign resp_id    = id_q;
  assign mult_en    = (state == BUSY);
  assign mult_clear = reset || (state == ISSUE);
  assign busy       = (state != IDLE);

`ifdef MULT_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (a_sel == '0) || (b_sel == '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      id_q        <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      resp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_grant) begin
            mult_a <= a_sel;
            mult_b <= b_sel;
            id_q   <= grant_idx;
            ptr    <= next_ptr;
`ifdef MULT_ZERO_BYPASS_EN
            if (zero_op) begin
              resp_result <= '0;
              state       <= RESP;
            end else begin
              state <= ISSUE;
            end
`else
            state <= ISSUE;
`endif
          end
        end
        ISSUE: state <= BUSY;
        BUSY: begin
          if (mult_done) begin
            resp_result <= mult_result;
            state       <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Self-checking bench for mult_share_sched with a behavioural multiplier and RR model.
module tb_mult_share_sched;

  localparam int N   = 32;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*N-1:0] req_a;
  logic [NR*N-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [2*N-1:0]  resp_result;
  logic            mult_clear;
  logic            mult_en;
  logic [N-1:0]    mult_a;
  logic [N-1:0]    mult_b;
  logic [2*N-1:0]  mult_result;
  logic            mult_done;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ptr  = 0;
  bit model_off = 1'b0;

  mult_share_sched #(.N(N), .NUM_REQ(NR)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .mult_clear  (mult_clear),
    .mult_en     (mult_en),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_result (mult_result),
    .mult_done   (mult_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: after a clear, finishes 0..4 enabled cycles later.
  initial begin : mult_model
    int cnt;
    bit sent;
    cnt = 0;
    sent = 1'b1;
    mult_done = 1'b0;
    mult_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!model_off) begin
        mult_done = 1'b0;
        if (mult_clear) begin
          cnt  = $urandom_range(0, 4);
          sent = 1'b0;
        end else if (mult_en && !sent) begin
          if (cnt == 0) begin
            mult_done   = 1'b1;
            mult_result = 64'(mult_a) * 64'(mult_b);
            sent        = 1'b1;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic wait_resp(output bit ok);
    int cyc;
    cyc = 0;
    while (!resp_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    ok = resp_valid;
  endtask

  // Reference arbitration: first valid requester at or after the pointer, cyclically.
  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int g);
    logic [NR-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    resp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    #1;
    n_checks++;
    if (mult_clear !== 1'b1) begin
      n_fail++; $display("FAIL reset_clear: got %b want 1", mult_clear);
    end
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    reset = 1'b0;
    req_valid = '0;
    exp_ptr = 0;
    #1;
    n_checks++;
    if ({busy, resp_valid, mult_en, mult_clear} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {busy, resp_valid, mult_en, mult_clear});
    end
    n_checks++;
    if ({mult_a, mult_b} !== 64'd0) begin
      n_fail++; $display("FAIL reset_operands: got %h want 0", {mult_a, mult_b});
    end
    n_checks++;
    if ({resp_id, resp_result} !== '0) begin
      n_fail++; $display("FAIL reset_resp: got id %0d result %h want 0", resp_id, resp_result);
    end
  endtask

  task automatic test_single();
    bit ok;
    set_slot(0, 32'd7, 32'd6);
    req_valid = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    exp_ptr = 1;
    #1;
    n_checks++;
    if ({mult_clear, mult_en, busy} !== 3'b101) begin
      n_fail++; $display("FAIL single_issue: got clr/en/busy %b want 101", {mult_clear, mult_en, busy});
    end
    n_checks++;
    if (mult_a !== 32'd7 || mult_b !== 32'd6) begin
      n_fail++; $display("FAIL single_operands: got %0d,%0d want 7,6", mult_a, mult_b);
    end
    tick();
    #1;
    n_checks++;
    if ({mult_clear, mult_en} !== 2'b01) begin
      n_fail++; $display("FAIL single_busy: got clr/en %b want 01", {mult_clear, mult_en});
    end
    wait_resp(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL single_timeout: resp_valid %b want 1", ok);
    end
    n_checks++;
    if (resp_id !== 2'd0 || resp_result !== 64'd42) begin
      n_fail++; $display("FAIL single_result: got id %0d result %0d want id 0 result 42", resp_id, resp_result);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_checks++;
    if ({resp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_release: got valid/busy %b want 00", {resp_valid, busy});
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int g;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ptr = 0;
    for (int i = 0; i < NR; i++) set_slot(i, 32'(i + 1), 32'd3);
    req_valid = '1;
    for (int j = 0; j < 5; j++) begin
      g = rr_pick(req_valid, exp_ptr);
      #1;
      n_checks++;
      if (req_ready !== onehot(g)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", j, req_ready, onehot(g));
      end
      tick();
      exp_ptr = (g + 1) % NR;
      wait_resp(ok);
      n_checks++;
      if (ok !== 1'b1 || resp_id !== IDW'(g) || resp_result !== 64'((g + 1) * 3)) begin
        n_fail++; $display("FAIL rr_resp[%0d]: got ok %b id %0d result %0d want id %0d result %0d",
                           j, ok, resp_id, resp_result, g, (g + 1) * 3);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int g;
    logic [2*N-1:0] exp_r;
    set_slot(1, 32'd11, 32'd13);
    set_slot(2, 32'd5, 32'd17);
    req_valid = 4'b0110;
    g = rr_pick(req_valid, exp_ptr);
    exp_r = (g == 1) ? 64'd143 : 64'd85;
    tick();
    exp_ptr = (g + 1) % NR;
    wait_resp(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL bp_timeout: resp_valid %b want 1", ok);
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (resp_valid !== 1'b1 || resp_result !== exp_r || resp_id !== IDW'(g) || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid %b id %0d result %0d ready %b want 1 %0d %0d 0000",
                           c, resp_valid, resp_id, resp_result, req_ready, g, exp_r);
      end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL bp_handshake_ready: got %b want 0000", req_ready);
    end
    tick();
    resp_ready = 1'b0;
    g = rr_pick(req_valid, exp_ptr);
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== onehot(g)) begin
      n_fail++; $display("FAIL bp_next_grant: got valid %b ready %b want 0 %b", resp_valid, req_ready, onehot(g));
    end
    tick();
    req_valid = '0;
    exp_ptr = (g + 1) % NR;
    n_checks++;
    if ({busy, mult_clear} !== 2'b11) begin
      n_fail++; $display("FAIL bp_accept: got busy/clr %b want 11", {busy, mult_clear});
    end
    wait_resp(ok);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_max();
    bit ok;
    set_slot(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    exp_ptr = 0;
    wait_resp(ok);
    n_checks++;
    if (ok !== 1'b1 || resp_id !== 2'd3 || resp_result !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++; $display("FAIL max_result: got ok %b id %0d result %h want id 3 result fffffffe00000001",
                         ok, resp_id, resp_result);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    int g;
    int hold;
    logic [NR-1:0] mask;
    logic [N-1:0] ea, eb;
    logic [2*N-1:0] er;
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < NR; i++) begin
        ea = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
        eb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
        set_slot(i, ea, eb);
      end
      mask = NR'($urandom_range(0, 15));
      req_valid = mask;
      g = rr_pick(mask, exp_ptr);
      #1;
      n_checks++;
      if (req_ready !== onehot(g)) begin
        n_fail++; $display("FAIL rand_grant[%0d]: got %b want %b (mask %b ptr %0d)", j, req_ready, onehot(g), mask, exp_ptr);
      end
      if (g < 0) begin
        tick();
        continue;
      end
      ea = req_a[g*N +: N];
      eb = req_b[g*N +: N];
      er = 64'(ea) * 64'(eb);
      tick();
      exp_ptr = (g + 1) % NR;
      req_valid = NR'($urandom_range(0, 15));
      #1;
      n_checks++;
      if (req_ready !== 4'b0000 || mult_a !== ea || mult_b !== eb) begin
        n_fail++; $display("FAIL rand_latch[%0d]: got ready %b a %h b %h want 0000 %h %h", j, req_ready, mult_a, mult_b, ea, eb);
      end
      wait_resp(ok);
      hold = $urandom_range(0, 3);
      for (int c = 0; c < hold; c++) tick();
      n_checks++;
      if (ok !== 1'b1 || resp_valid !== 1'b1 || resp_id !== IDW'(g) || resp_result !== er) begin
        n_fail++; $display("FAIL rand_resp[%0d]: got ok %b id %0d result %h want id %0d result %h", j, ok, resp_id, resp_result, g, er);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end
    req_valid = '0;
  endtask

  task automatic test_reset_busy();
    set_slot(2, 32'd21, 32'd2);
    req_valid = 4'b0100;
    model_off = 1'b1;
    mult_done = 1'b0;
    tick();
    req_valid = '0;
    tick();
    #1;
    n_checks++;
    if (mult_en !== 1'b1) begin
      n_fail++; $display("FAIL rb_busy: got mult_en %b want 1", mult_en);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (mult_clear !== 1'b1) begin
      n_fail++; $display("FAIL rb_clear: got %b want 1", mult_clear);
    end
    tick();
    tick();
    reset = 1'b0;
    exp_ptr = 0;
    mult_result = 64'hDEAD_BEEF;
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({resp_valid, busy, mult_en} !== 3'b000) begin
        n_fail++; $display("FAIL rb_idle[%0d]: got valid/busy/en %b want 000", c, {resp_valid, busy, mult_en});
      end
      tick();
    end
    req_valid = '1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rb_ptr: got %b want 0001", req_ready);
    end
    req_valid = '0;
    model_off = 1'b0;
  endtask

  task automatic test_zero();
    bit ok;
    set_slot(2, 32'd0, 32'd9);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    exp_ptr = 3;
    n_checks++;
    if (mult_a !== 32'd0 || mult_b !== 32'd9) begin
      n_fail++; $display("FAIL zero_latch: got %0d,%0d want 0,9", mult_a, mult_b);
    end
`ifdef MULT_ZERO_BYPASS_EN
    n_checks++;
    if ({resp_valid, mult_clear, mult_en} !== 3'b100) begin
      n_fail++; $display("FAIL zero_bypass: got valid/clr/en %b want 100", {resp_valid, mult_clear, mult_en});
    end
    ok = resp_valid;
`else
    n_checks++;
    if ({resp_valid, mult_clear} !== 2'b01) begin
      n_fail++; $display("FAIL zero_normal: got valid/clr %b want 01", {resp_valid, mult_clear});
    end
    wait_resp(ok);
`endif
    n_checks++;
    if (ok !== 1'b1 || resp_id !== 2'd2 || resp_result !== 64'd0) begin
      n_fail++; $display("FAIL zero_result: got ok %b id %0d result %h want id 2 result 0", ok, resp_id, resp_result);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_max();
    test_random();
    test_reset_busy();
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
